// File: rtl/sram_responder.sv
// Dual-port SRAM responder: read-only instruction port, byte-write data port,
// 1-cycle registered read data, out-of-range error pulses and access counters.
module sram_responder #(
    parameter logic [31:0] ADDR_BASE  = 32'h1c000000,
    parameter int          DEPTH_LOG2 = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        inst_err,
    output logic        data_err,
    output logic [31:0] inst_rd_cnt,
    output logic [31:0] data_rd_cnt,
    output logic [31:0] data_wr_cnt
);
    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

    logic [31:0] r_mem [DEPTH];

    logic [31:0]           w_i_off, w_d_off;
    logic                  w_i_inr, w_d_inr;
    logic [DEPTH_LOG2-1:0] w_i_idx, w_d_idx;
    logic                  w_i_acc, w_d_acc, w_d_wr;
    logic                  w_unused;

    // Offsets wrap modulo 2^32, so addresses below the base land out of range.
    assign w_i_off  = inst_sram_addr - ADDR_BASE;
    assign w_d_off  = data_sram_addr - ADDR_BASE;
    assign w_i_inr  = {1'b0, w_i_off} < LIMIT;
    assign w_d_inr  = {1'b0, w_d_off} < LIMIT;
    assign w_i_idx  = w_i_off[DEPTH_LOG2+1:2];
    assign w_d_idx  = w_d_off[DEPTH_LOG2+1:2];
    assign w_i_acc  = inst_sram_en && !reset;
    assign w_d_acc  = data_sram_en && !reset;
    assign w_d_wr   = w_d_acc && (data_sram_wen != 4'h0);
    assign w_unused = ^inst_sram_wdata;

    // Array is never reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_d_wr && w_d_inr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wen[b])
                    r_mem[w_d_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write lands: read-first on
    // both ports, including inst-vs-data collisions.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            inst_err        <= 1'b0;
            data_err        <= 1'b0;
            inst_rd_cnt     <= 32'h0;
            data_rd_cnt     <= 32'h0;
            data_wr_cnt     <= 32'h0;
        end else begin
            inst_err <= w_i_acc && (!w_i_inr || (inst_sram_wen != 4'h0));
            data_err <= w_d_acc && !w_d_inr;
            if (w_i_acc) begin
                inst_sram_rdata <= w_i_inr ? r_mem[w_i_idx] : 32'h0;
                inst_rd_cnt     <= inst_rd_cnt + 32'd1;
            end
            if (w_d_acc) begin
                data_sram_rdata <= w_d_inr ? r_mem[w_d_idx] : 32'h0;
                if (w_d_wr)
                    data_wr_cnt <= data_wr_cnt + 32'd1;
                else
                    data_rd_cnt <= data_rd_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: write/readback, byte merge, collision,
// out-of-range, instruction-port errors and mid-stream reset.
module tb_sram_responder;
    localparam logic [31:0] B = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        inst_err, data_err;
    logic [31:0] inst_rd_cnt, data_rd_cnt, data_wr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    sram_responder dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .inst_err(inst_err), .data_err(data_err),
        .inst_rd_cnt(inst_rd_cnt), .data_rd_cnt(data_rd_cnt),
        .data_wr_cnt(data_wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Present one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic go(input logic rst,
                      input logic ie, input logic [3:0] iw, input logic [31:0] ia,
                      input logic de, input logic [3:0] dw, input logic [31:0] da,
                      input logic [31:0] dd);
        reset = rst;
        inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia;
        inst_sram_wdata = 32'hffffffff;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da;
        data_sram_wdata = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        go(0, 0, 4'h0, B, 0, 4'h0, B, 32'h0);
    endtask

    initial begin
        go(1, 0, 4'h0, B, 0, 4'h0, B, 32'h0);
        go(1, 0, 4'h0, B, 0, 4'h0, B, 32'h0);
        chk("rst_irdata", inst_sram_rdata, 32'h0);
        chk("rst_drdata", data_sram_rdata, 32'h0);
        chk("rst_errs",   {30'h0, inst_err, data_err}, 32'h0);
        chk("rst_ircnt",  inst_rd_cnt, 32'h0);
        chk("rst_drcnt",  data_rd_cnt, 32'h0);
        chk("rst_dwcnt",  data_wr_cnt, 32'h0);

        // 1: full-word write then readback on both ports
        go(0, 0, 4'h0, B, 1, 4'hf, B + 32'h10, 32'h12345678);
        go(0, 1, 4'h0, B + 32'h10, 1, 4'h0, B + 32'h10, 32'h0);
        chk("t1_drdata", data_sram_rdata, 32'h12345678);
        chk("t1_irdata", inst_sram_rdata, 32'h12345678);
        chk("t1_dwcnt",  data_wr_cnt, 32'd1);
        chk("t1_drcnt",  data_rd_cnt, 32'd1);
        chk("t1_ircnt",  inst_rd_cnt, 32'd1);

        // 2: byte merge, read-first
        go(0, 0, 4'h0, B, 1, 4'b0101, B + 32'h10, 32'haabbccdd);
        chk("t2_readfirst", data_sram_rdata, 32'h12345678);
        go(0, 0, 4'h0, B, 1, 4'h0, B + 32'h10, 32'h0);
        chk("t2_merge", data_sram_rdata, 32'h12bb56dd);
        chk("t2_dwcnt", data_wr_cnt, 32'd2);

        // 3: same-cycle data write / inst read collision
        go(0, 0, 4'h0, B, 1, 4'hf, B + 32'h20, 32'h0);
        go(0, 1, 4'h0, B + 32'h20, 1, 4'hf, B + 32'h20, 32'hdeadbeef);
        chk("t3_collide_i", inst_sram_rdata, 32'h0);
        chk("t3_collide_d", data_sram_rdata, 32'h0);
        idle();
        chk("t3_hold", inst_sram_rdata, 32'h0);
        go(0, 1, 4'h0, B + 32'h20, 0, 4'h0, B, 32'h0);
        chk("t3_after", inst_sram_rdata, 32'hdeadbeef);

        // 4: out-of-range data write
        go(0, 0, 4'h0, B, 1, 4'hf, B, 32'hcafef00d);
        go(0, 0, 4'h0, B, 1, 4'hf, B + 32'h10000, 32'hffffffff);
        chk("t4_derr",   {31'h0, data_err}, 32'd1);
        chk("t4_drdata", data_sram_rdata, 32'h0);
        chk("t4_dwcnt",  data_wr_cnt, 32'd6);
        idle();
        chk("t4_derr_off", {31'h0, data_err}, 32'd0);
        go(0, 0, 4'h0, B, 1, 4'h0, B, 32'h0);
        chk("t4_word0", data_sram_rdata, 32'hcafef00d);
        chk("t4_drcnt", data_rd_cnt, 32'd3);
        chk("t4_ierr",  {31'h0, inst_err}, 32'd0);

        // 5: instruction port wen error, unaligned read, below-base address
        go(0, 0, 4'h0, B, 1, 4'hf, B + 32'h30, 32'h55);
        go(0, 1, 4'h1, B + 32'h30, 0, 4'h0, B, 32'h0);
        chk("t5_wen_rdata", inst_sram_rdata, 32'h55);
        chk("t5_wen_err",   {31'h0, inst_err}, 32'd1);
        idle();
        chk("t5_err_off", {31'h0, inst_err}, 32'd0);
        go(0, 1, 4'h0, B + 32'h30, 0, 4'h0, B, 32'h0);
        chk("t5_unchanged", inst_sram_rdata, 32'h55);
        go(0, 1, 4'h0, B + 32'h12, 0, 4'h0, B, 32'h0);
        chk("t5_unaligned", inst_sram_rdata, 32'h12bb56dd);
        chk("t5_ok_err",    {31'h0, inst_err}, 32'd0);
        go(0, 1, 4'h0, B - 32'h4, 0, 4'h0, B, 32'h0);
        chk("t5_oor_rdata", inst_sram_rdata, 32'h0);
        chk("t5_oor_err",   {31'h0, inst_err}, 32'd1);
        chk("t5_ircnt",     inst_rd_cnt, 32'd7);

        // 6: reset mid-stream with enables held high
        go(0, 0, 4'h0, B, 1, 4'hf, B + 32'h40, 32'h0badf00d);
        go(1, 1, 4'h0, B + 32'h40, 1, 4'hf, B + 32'h40, 32'h11111111);
        go(1, 1, 4'h0, B + 32'h40, 1, 4'hf, B + 32'h40, 32'h11111111);
        chk("t6_drdata", data_sram_rdata, 32'h0);
        chk("t6_irdata", inst_sram_rdata, 32'h0);
        chk("t6_errs",   {30'h0, inst_err, data_err}, 32'h0);
        chk("t6_cnts",   inst_rd_cnt | data_rd_cnt | data_wr_cnt, 32'h0);
        idle();
        chk("t6_dwcnt_rel", data_wr_cnt, 32'h0);
        go(0, 0, 4'h0, B, 1, 4'h0, B + 32'h40, 32'h0);
        chk("t6_survive", data_sram_rdata, 32'h0badf00d);
        chk("t6_drcnt",   data_rd_cnt, 32'd1);
        chk("t6_dwcnt",   data_wr_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synchronous dual-port SRAM responder. It is the memory side of the sram-like interface that the IF stage (instruction port) and the MEM stage (data port) drive as initiators.
- Each port returns read data exactly one cycle after an enabled access and applies byte-enable writes.
- Tracks out-of-range accesses and per-port access counts for bench and debug visibility.
- Used as the memory model in simulation and as the on-chip RAM wrapper in synthesis.

Parameters:
- ADDR_BASE, 32'h1c000000, byte address mapped to word 0.
- DEPTH_LOG2, 14, log2 of word count (default 16K words = 64 KB).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- inst_sram_en  input  1  instruction port access enable
- inst_sram_wen  input  4  instruction port byte write enable; must be 0
- inst_sram_addr  input  32  instruction port byte address
- inst_sram_wdata  input  32  instruction port write data; ignored
- inst_sram_rdata  output  32  instruction read data, valid the cycle after en
- data_sram_en  input  1  data port access enable
- data_sram_wen  input  4  data port byte write enable; bit i writes byte i
- data_sram_addr  input  32  data port byte address
- data_sram_wdata  input  32  data port write data
- data_sram_rdata  output  32  data read data, valid the cycle after en
- inst_err  output  1  one-cycle pulse: instruction port out of range or wen≠0
- data_err  output  1  one-cycle pulse: data port out of range
- inst_rd_cnt  output  32  count of accepted instruction reads
- data_rd_cnt  output  32  count of accepted data reads (wen==0)
- data_wr_cnt  output  32  count of accepted data writes (wen≠0)

Behaviour:
- Address decode, per port: off = addr - ADDR_BASE (32-bit wrap). In range iff off < 4<<DEPTH_LOG2. Word index = off[DEPTH_LOG2+1:2]; addr[1:0] is ignored, since the initiator raises alignment exceptions itself.
- Read latency is 1 cycle. On a cycle with en=1 and reset=0, rdata is registered at the next clock edge. With en=0, rdata holds its previous value.
- Read-first on every access. An enabled data write returns the pre-write word on data_sram_rdata.
- Same-cycle inst read and data write to the same word: inst_sram_rdata gets the old word. The new word is visible from the following access.
- Data write merge: byte i of the word is replaced by wdata[8i+7:8i] iff wen[i]=1. wen=4'hf is a full-word write.
- Instruction port is read-only. An access with wen≠0 still performs the read, performs no write, and pulses inst_err the next cycle.
- Out-of-range access, either port: the write is dropped, rdata = 32'h0 the next cycle, the err pulse is raised the next cycle, and the counter still increments (the access was accepted).
- Counters increment by 1 per enabled non-reset cycle in their class and wrap modulo 2^32.
- err outputs are registered: high for exactly one cycle following the offending access, low otherwise.
- Reset, registered outputs: rdata = 0, err = 0, all counters = 0 on the edge where reset=1.
- Reset, accesses: any access presented while reset=1 is ignored (no write, no count).
- Reset, memory: array contents are NOT cleared.
- Reset mid-operation: an access issued the cycle before reset is asserted has its rdata overwritten to 0 by reset. The bench must not expect it.
- No back-pressure and no ready signal. Every enabled non-reset cycle is accepted.

Test Plan:
1. Full-word write, then readback. Data write addr 0x1c000010, wen f, wdata 0x12345678. Next cycle: data read 0x1c000010 and inst read 0x1c000010. One cycle later both rdata = 0x12345678. data_wr_cnt = 1, data_rd_cnt = 1, inst_rd_cnt = 1.
2. Byte merge and read-first. Word holds 0x12345678. Write wen 4'b0101, wdata 0xaabbccdd: rdata that cycle = 0x12345678 (old word). A subsequent read returns 0x12bb56dd.
3. Same-cycle collision. Word holds 0x0. Data write 0xdeadbeef and inst read to the same address in the same cycle: inst_sram_rdata = 0x0. Next inst read returns 0xdeadbeef.
4. Out-of-range write. Data write 0x1c000000 + (4<<DEPTH_LOG2): data_err pulses exactly one cycle, rdata = 0, data_wr_cnt increments. Reading 0x1c000000 is unchanged.
5. Instruction port error and address handling.
   - Inst access with wen=4'h1 to a word holding 0x55: rdata = 0x55, inst_err = 1 for one cycle, memory unchanged.
   - Unaligned inst read 0x1c000012 returns the word at 0x1c000010.
6. Reset mid-stream. Issue a write followed by reset=1 for 2 cycles while en is held high: rdata = 0, counters = 0, err = 0, and writes during reset are dropped. After release, the pre-reset write's data is still readable.
